boot_loader: RTL and testbench
==============================

# boot_loader

Program loader that sits directly upstream of the CPU control unit and produces its `bootload_address` / `bootload_ram` requests. It accepts a byte stream over a valid/ready handshake and writes each byte into the 16-entry program RAM over the shared bus. For each byte it first drives the address into MAR, then the data into RAM. It holds the CPU in reset until a complete image has been loaded.

## Interface
Parameters:
- `MEM_DEPTH`, 16: number of bytes per image, one per RAM location, loaded in address order 0..MEM_DEPTH-1.
- `ADDR_W`, 4: address width; `MEM_DEPTH` = 2**`ADDR_W`.

Ports:
- `clk`  in  1  system clock; all state updates on posedge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  single-cycle request to begin loading an image.
- `byte_in`  in  8  incoming image byte.
- `byte_valid`  in  1  `byte_in` is valid.
- `byte_ready`  out  1  loader can accept a byte this cycle.
- `bootload_address`  out  1  to control: MAR reads the boot bus this cycle.
- `bootload_ram`  out  1  to control: RAM reads the boot bus this cycle.
- `boot_data`  out  8  value placed on the bus while control asserts `boot_write_to_bus`.
- `cpu_rst`  out  1  active-high reset to the rest of the CPU.
- `busy`  out  1  a load is in progress.
- `done`  out  1  the last load completed successfully.
- `err`  out  1  checksum failure (always 0 without `BOOT_CHECKSUM_EN`).

## Operation
- All outputs are registered (Moore).
- Reset values:
  - `byte_ready`, `bootload_address`, `bootload_ram`, `busy`, `done`, `err` = 0.
  - `boot_data` = 0.
  - `cpu_rst` = 1.
  - Address counter = 0; state = IDLE.
- States:
  - **IDLE**
    - `start` -> WAIT_BYTE.
    - Address is cleared and `done`/`err` are cleared on the transition.
    - `busy` = 1 from WAIT_BYTE until DONE or ERROR.
  - **WAIT_BYTE**
    - `byte_ready` = 1.
    - On `byte_valid & byte_ready`, latch `byte_in` -> ADDR.
  - **ADDR**
    - `bootload_address` = 1.
    - `boot_data` = zero-extended address counter.
    - Always -> DATA.
  - **DATA**
    - `bootload_ram` = 1.
    - `boot_data` = latched byte.
    - If address == `MEM_DEPTH`-1 -> DONE (or CHECK when checksum is enabled).
    - Otherwise increment the address -> WAIT_BYTE.
  - **DONE**
    - `done` = 1, `cpu_rst` = 0.
    - `start` -> WAIT_BYTE: reasserts `cpu_rst` in the same edge and clears `done`.
  - **CHECK** / **ERROR**: see Configuration.
- Signal rules:
  - `bootload_address` and `bootload_ram` are never high in the same cycle.
  - Both are 0 outside ADDR/DATA.
- `cpu_rst` = 1 in every state except DONE.
- `start` is ignored in WAIT_BYTE, ADDR, DATA and CHECK.
- `byte_valid` is ignored whenever `byte_ready` = 0. No byte is dropped; the source holds the byte until the handshake completes.
- Address wraps only by restart; the counter never counts past `MEM_DEPTH`-1.
- Deasserting `rst_n` mid-load returns immediately to the reset values. The RAM contents are left partial; recovery is a new `start`.

## Timing
- Handshake at edge N: `bootload_address` is high in cycle N+1, `bootload_ram` in N+2, and `byte_ready` is high again in N+3.
- Minimum is 3 cycles per byte, so a full 16-byte image takes 48 cycles after the first accepted byte.
- `start` sampled at edge S: `byte_ready` = 1 and `busy` = 1 from cycle S+1.
- The last DATA cycle ends at edge E. `done` = 1 and `cpu_rst` = 0 from E+1 without checksum, or from E+2 with checksum after a successful CHECK.
- Control decodes `bootload_*` combinationally. MAR and RAM capture on the posedge that ends the ADDR and DATA cycles respectively.

## Configuration
- Macro: `BOOT_CHECKSUM_EN`.
- Defined:
  - After the last DATA cycle the loader enters CHECK with `byte_ready` = 1 and accepts one extra byte.
  - This byte is not written to RAM.
  - It is compared with the 8-bit modulo-256 sum of the `MEM_DEPTH` image bytes.
  - Match -> DONE.
  - Mismatch -> ERROR: `err` = 1, `cpu_rst` = 1, `busy` = 0. `start` from ERROR clears `err` and -> WAIT_BYTE.
- Undefined:
  - No CHECK or ERROR states; DATA on the last address -> DONE.
  - `err` is tied to 0.

## Test plan
- Reset -> `cpu_rst` = 1, all other outputs 0. Assert `rst_n` low mid-load at byte 5 -> same values immediately, address restarts at 0 on the next `start`.
- `start`, then stream bytes 0x10..0x1F with `byte_valid` held high -> for each byte k, one cycle of `bootload_address` with `boot_data` = k, then one cycle of `bootload_ram` with `boot_data` = 0x10+k. After the last byte: `done` = 1, `cpu_rst` = 0, 48 cycles after the first handshake.
- Random `byte_valid` gaps of 0–5 cycles -> the same RAM writes in the same order. No byte is lost or duplicated, and `bootload_*` are never both high.
- `start` pulsed while busy at byte 7 -> ignored; the load completes normally.
- With `BOOT_CHECKSUM_EN`, image of sixteen 0x01 bytes:
  - Checksum 0x10 -> `done` = 1, `cpu_rst` = 0.
  - Checksum 0x11 -> `err` = 1, `cpu_rst` = 1, `done` = 0.
- `start` from DONE -> `cpu_rst` returns to 1 on the next cycle, `done` = 0, and a second image loads correctly.

Source files
------------

// File: rtl/boot_loader.sv
// Byte-stream program loader: writes MEM_DEPTH bytes into program RAM via MAR/RAM bus phases
// and holds the CPU in reset until a full image is in. Define BOOT_CHECKSUM_EN for a trailing checksum byte.
module boot_loader #(
  parameter int MEM_DEPTH = 16,
  parameter int ADDR_W    = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] byte_in,
  input  logic       byte_valid,
  output logic       byte_ready,
  output logic       bootload_address,
  output logic       bootload_ram,
  output logic [7:0] boot_data,
  output logic       cpu_rst,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MEM_DEPTH - 1);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_BYTE,
    ADDR,
    DATA,
    DONE
`ifdef BOOT_CHECKSUM_EN
    , CHECK,
    ERROR
`endif
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] addr;
  logic [7:0]        byte_q;
  logic              take_byte;
  logic              restart;

  assign take_byte = byte_valid & byte_ready;

  // A new load may only begin from a resting state; start is ignored mid-load.
  always_comb begin
    restart = 1'b0;
    if (start) begin
      case (state)
        IDLE, DONE: restart = 1'b1;
`ifdef BOOT_CHECKSUM_EN
        ERROR:      restart = 1'b1;
`endif
        default:    restart = 1'b0;
      endcase
    end
  end

`ifdef BOOT_CHECKSUM_EN
  logic [7:0] sum;
`else
  assign err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      addr             <= '0;
      byte_q           <= '0;
      byte_ready       <= 1'b0;
      bootload_address <= 1'b0;
      bootload_ram     <= 1'b0;
      boot_data        <= '0;
      cpu_rst          <= 1'b1;
      busy             <= 1'b0;
      done             <= 1'b0;
`ifdef BOOT_CHECKSUM_EN
      sum              <= '0;
      err              <= 1'b0;
`endif
    end else if (restart) begin
      state      <= WAIT_BYTE;
      addr       <= '0;
      byte_ready <= 1'b1;
      busy       <= 1'b1;
      done       <= 1'b0;
      cpu_rst    <= 1'b1;
`ifdef BOOT_CHECKSUM_EN
      sum        <= '0;
      err        <= 1'b0;
`endif
    end else begin
      case (state)
        WAIT_BYTE: begin
          if (take_byte) begin
            byte_q           <= byte_in;
            byte_ready       <= 1'b0;
            bootload_address <= 1'b1;
            boot_data        <= 8'(addr);
            state            <= ADDR;
`ifdef BOOT_CHECKSUM_EN
            sum              <= sum + byte_in;
`endif
          end
        end
        ADDR: begin
          bootload_address <= 1'b0;
          bootload_ram     <= 1'b1;
          boot_data        <= byte_q;
          state            <= DATA;
        end
        DATA: begin
          bootload_ram <= 1'b0;
          if (addr == LAST_ADDR) begin
`ifdef BOOT_CHECKSUM_EN
            byte_ready <= 1'b1;
            state      <= CHECK;
`else
            done       <= 1'b1;
            cpu_rst    <= 1'b0;
            busy       <= 1'b0;
            state      <= DONE;
`endif
          end else begin
            addr       <= addr + 1'b1;
            byte_ready <= 1'b1;
            state      <= WAIT_BYTE;
          end
        end
`ifdef BOOT_CHECKSUM_EN
        // The trailing byte is only compared, never written to RAM.
        CHECK: begin
          if (take_byte) begin
            byte_ready <= 1'b0;
            busy       <= 1'b0;
            if (byte_in == sum) begin
              done    <= 1'b1;
              cpu_rst <= 1'b0;
              state   <= DONE;
            end else begin
              err     <= 1'b1;
              state   <= ERROR;
            end
          end
        end
        ERROR: state <= ERROR;
`endif
        IDLE:    state <= IDLE;
        DONE:    state <= DONE;
        default: state <= IDLE;
      endcase
    end
  end

  a_bus_exclusive: assert property (@(posedge clk) disable iff (!rst_n)
    !(bootload_address && bootload_ram));

  a_cpu_released_only_when_done: assert property (@(posedge clk) disable iff (!rst_n)
    cpu_rst == !done);

endmodule

// File: tb/tb_boot_loader.sv
// Randomized scoreboard bench for boot_loader: expected RAM writes are queued at each
// handshake and popped by an independent bus monitor.
module tb_boot_loader;

  localparam int MEM_DEPTH = 16;
  localparam int ADDR_W    = 4;
`ifdef BOOT_CHECKSUM_EN
  localparam int EXP_LAT = 49;
`else
  localparam int EXP_LAT = 48;
`endif

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] byte_in;
  logic       byte_valid;
  logic       byte_ready;
  logic       bootload_address;
  logic       bootload_ram;
  logic [7:0] boot_data;
  logic       cpu_rst;
  logic       busy;
  logic       done;
  logic       err;

  boot_loader #(.MEM_DEPTH(MEM_DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .byte_in(byte_in),
    .byte_valid(byte_valid),
    .byte_ready(byte_ready),
    .bootload_address(bootload_address),
    .bootload_ram(bootload_ram),
    .boot_data(boot_data),
    .cpu_rst(cpu_rst),
    .busy(busy),
    .done(done),
    .err(err)
  );

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [7:0]        data;
  } wr_t;

  wr_t        exp_q[$];
  wr_t        mon_e;
  logic [7:0] img[MEM_DEPTH];
  int         n_checks = 0;
  int         n_pass = 0;
  int         cyc = 0;
  int         first_cyc = 0;
  int         last_lat = 0;
  bit         have_addr = 0;
  logic [7:0] last_addr = '0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Bus monitor: every RAM phase must be preceded by an address phase and match the next queued write.
  always @(negedge clk) begin
    if (!rst_n) begin
      have_addr = 0;
    end else begin
      if (bootload_address || bootload_ram)
        checkOutput("bus_exclusive", {31'b0, bootload_address & bootload_ram}, 0);
      if (bootload_address) begin
        have_addr = 1;
        last_addr = boot_data;
      end
      if (bootload_ram) begin
        checkOutput("addr_before_data", {31'b0, have_addr}, 1);
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_write", 1, 0);
        end else begin
          mon_e = exp_q.pop_front();
          checkOutput("ram_addr", {24'b0, last_addr}, {28'b0, mon_e.addr});
          checkOutput("ram_data", {24'b0, boot_data}, {24'b0, mon_e.data});
        end
        have_addr = 0;
      end
    end
  end

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, "_cpu_rst"}, {31'b0, cpu_rst}, 1);
    checkOutput({tag, "_byte_ready"}, {31'b0, byte_ready}, 0);
    checkOutput({tag, "_bootload_address"}, {31'b0, bootload_address}, 0);
    checkOutput({tag, "_bootload_ram"}, {31'b0, bootload_ram}, 0);
    checkOutput({tag, "_boot_data"}, {24'b0, boot_data}, 0);
    checkOutput({tag, "_busy"}, {31'b0, busy}, 0);
    checkOutput({tag, "_done"}, {31'b0, done}, 0);
    checkOutput({tag, "_err"}, {31'b0, err}, 0);
  endtask

  task automatic sendByte(input logic [7:0] b, input int gap, output bit ok, output int hs_cyc);
    repeat (gap) begin
      byte_valid = 1'b0;
      @(posedge clk); #1;
    end
    byte_valid = 1'b1;
    byte_in    = b;
    ok         = 0;
    hs_cyc     = 0;
    for (int t = 0; t < 60; t++) begin
      @(negedge clk);
      if (byte_ready) begin
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      checkOutput("handshake_timeout", 0, 1);
      byte_valid = 1'b0;
      return;
    end
    hs_cyc = cyc;
    @(posedge clk); #1;
  endtask

  task automatic applyStimulus(input int max_gap, input int pulse_at, input int abort_at,
                               input logic [7:0] chk, input bit do_start);
    bit         ok;
    int         hs;
    bit         fin;
    logic [7:0] s;
    bit         exp_ok;
    if (do_start) begin
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      checkOutput("start_busy", {31'b0, busy}, 1);
      checkOutput("start_byte_ready", {31'b0, byte_ready}, 1);
    end
    for (int k = 0; k < MEM_DEPTH; k++) begin
      if (k == pulse_at) begin
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        checkOutput("start_ignored_busy", {31'b0, busy}, 1);
      end
      sendByte(img[k], int'($urandom_range(max_gap, 0)), ok, hs);
      if (!ok) return;
      if (k == 0) first_cyc = hs;
      exp_q.push_back('{addr: ADDR_W'(k), data: img[k]});
      if (k == abort_at) begin
        byte_valid = 1'b0;
        return;
      end
    end
`ifdef BOOT_CHECKSUM_EN
    sendByte(chk, int'($urandom_range(max_gap, 0)), ok, hs);
    if (!ok) return;
`endif
    byte_valid = 1'b0;
    fin = 0;
    for (int t = 0; t < 40; t++) begin
      @(negedge clk);
      if (done || err) begin
        fin = 1;
        break;
      end
    end
    checkOutput("load_finished", {31'b0, fin}, 1);
    last_lat = cyc - first_cyc;
    s = '0;
    for (int k = 0; k < MEM_DEPTH; k++) s = s + img[k];
    exp_ok = 1;
`ifdef BOOT_CHECKSUM_EN
    exp_ok = (chk == s);
`endif
    checkOutput("end_done", {31'b0, done}, {31'b0, exp_ok});
    checkOutput("end_err", {31'b0, err}, {31'b0, !exp_ok});
    checkOutput("end_cpu_rst", {31'b0, cpu_rst}, {31'b0, !exp_ok});
    checkOutput("end_busy", {31'b0, busy}, 0);
    checkOutput("end_byte_ready", {31'b0, byte_ready}, 0);
    checkOutput("end_queue_drained", exp_q.size(), 0);
  endtask

  task automatic randomImage();
    for (int k = 0; k < MEM_DEPTH; k++) img[k] = 8'($urandom);
  endtask

  function automatic logic [7:0] imageSum();
    logic [7:0] s;
    s = '0;
    for (int k = 0; k < MEM_DEPTH; k++) s = s + img[k];
    return s;
  endfunction

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n      = 1'b0;
    start      = 1'b0;
    byte_in    = '0;
    byte_valid = 1'b0;
    #12;
    checkIdleOutputs("reset");
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    $display("[TB] image 0x10..0x1F, no gaps");
    for (int k = 0; k < MEM_DEPTH; k++) img[k] = 8'(8'h10 + k);
    applyStimulus(0, -1, -1, imageSum(), 1);
    checkOutput("load_latency", last_lat, EXP_LAT);

    $display("[TB] restart from DONE, random gaps");
    randomImage();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    checkOutput("restart_cpu_rst", {31'b0, cpu_rst}, 1);
    checkOutput("restart_done", {31'b0, done}, 0);
    checkOutput("restart_busy", {31'b0, busy}, 1);
    checkOutput("restart_byte_ready", {31'b0, byte_ready}, 1);
    applyStimulus(5, -1, -1, imageSum(), 0);

    $display("[TB] start pulsed while busy at byte 7");
    randomImage();
    applyStimulus(5, 7, -1, imageSum(), 1);

    $display("[TB] reset mid-load at byte 5");
    randomImage();
    applyStimulus(2, -1, 5, imageSum(), 1);
    #2 rst_n = 1'b0;
    #1;
    checkIdleOutputs("midreset");
    exp_q.delete();
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    randomImage();
    applyStimulus(5, -1, -1, imageSum(), 1);

`ifdef BOOT_CHECKSUM_EN
    $display("[TB] checksum good and bad");
    for (int k = 0; k < MEM_DEPTH; k++) img[k] = 8'h01;
    applyStimulus(0, -1, -1, 8'h10, 1);
    applyStimulus(0, -1, -1, 8'h11, 1);
    randomImage();
    applyStimulus(3, -1, -1, imageSum(), 1);
`endif

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
